// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS32 definitions. Holds the primary opcodes that the
//               control unit decodes, the encoder's op-class enum and the
//               encoder state enum.
// Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26]), shared with the control unit
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Descriptor operation class; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_J   = 3'd1,
        CLS_BEQ = 3'd2,
        CLS_BNE = 3'd3,
        CLS_LW  = 3'd4,
        CLS_SW  = 3'd5
    } op_class_t;

    // Encoder control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational MIPS32 field packer. Turns an op class plus
//               register/immediate/target fields into a 32-bit instruction
//               word and flags op classes that have no encoding.
// Revision    : 1.0  initial release
// ============================================================================
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    // Select the instruction format for the op class; unused fields ignored
    always_comb begin
        o_word    = 32'd0;
        o_illegal = 1'b0;
        case (op_class_t'(i_op))
            CLS_R:   o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, i_funct};
            CLS_J:   o_word = {OP_J, i_target};
            CLS_BEQ: o_word = {OP_BEQ, i_rs, i_rt, i_imm};
            CLS_BNE: o_word = {OP_BNE, i_rs, i_rt, i_imm};
            CLS_LW:  o_word = {OP_LW, i_rs, i_rt, i_imm};
            CLS_SW:  o_word = {OP_SW, i_rs, i_rt, i_imm};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Sequential MIPS32 instruction encoder / instruction-memory
//               writer. Accepts descriptors over valid/ready, packs them and
//               writes the words to consecutive word addresses until the
//               memory is full.
//               Optional macro INSTR_ENCODER_CHECKSUM_EN adds a running XOR
//               checksum output of all words written since start.
// Revision    : 1.0  initial release
// ============================================================================
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
`ifdef INSTR_ENCODER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_err;
    logic [31:0]         w_word;
    logic                w_illegal;
    logic                w_full;
    logic                w_accept;

    instr_pack u_pack (
        .i_op      (in_op),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_funct   (in_funct),
        .i_imm     (in_imm),
        .i_target  (in_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Full flag and handshake derive directly from state/count so that a
    // start pulse blocks acceptance in the same cycle
    assign w_full   = (r_count == c_DEPTH);
    assign in_ready = (r_state == ST_RUN) && !w_full && !start;
    assign w_accept = in_valid && in_ready;
    assign full     = w_full;
    assign count    = r_count;
    assign err      = r_err;

    // Control FSM, write pointer and registered memory-write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                r_state <= ST_RUN;
                r_ptr   <= '0;
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_illegal) begin
                    // Descriptor is consumed but produces no write
                    r_err <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= r_ptr;
                    mem_wdata <= w_word;
                    r_ptr     <= r_ptr + ADDR_W'(1);
                    r_count   <= r_count + (ADDR_W+1)'(1);
                    if (r_count + (ADDR_W+1)'(1) == c_DEPTH) begin
                        r_state <= ST_FULL;
                    end
                end
            end
        end
    end

`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Fold each strobed word into the running XOR one edge after the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= 32'd0;
        end else if (start) begin
            r_checksum <= 32'd0;
        end else if (mem_we) begin
            r_checksum <= r_checksum ^ mem_wdata;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder with a small memory
//               (ADDR_W=2) so the full/stall boundary is reachable quickly.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
`ifdef INSTR_ENCODER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference encoding from the MIPS field layout, built arithmetically
    function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt,
                                            input int rd, input int fn, input int imm,
                                            input int tg);
        longint opc;
        longint w;
        case (op)
            1: opc = 2;
            2: opc = 4;
            3: opc = 5;
            4: opc = 35;
            5: opc = 43;
            default: opc = 0;
        endcase
        if (op == 0)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn;
        else if (op == 1)
            w = opc * 67108864 + tg;
        else
            w = opc * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
        return w[31:0];
    endfunction

    // Apply one cycle of inputs (called 1 time unit after a rising edge);
    // returns in_ready as seen before the edge, leaves time 1 after the edge
    task automatic drive(input logic st, input logic v, input logic [2:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] fn, input logic [15:0] imm,
                         input logic [25:0] tg, output logic rdy);
        start = st; in_valid = v; in_op = op;
        in_rs = rs; in_rt = rt; in_rd = rd;
        in_funct = fn; in_imm = imm; in_target = tg;
        #1;
        rdy = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        logic r;
        drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, r);
    endtask

    task automatic do_start();
        logic r;
        drive(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, r);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_op = 3'd0;
        in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_funct = 6'h20;
        in_imm = 16'd0; in_target = 26'd0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", in_ready); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we); end
        n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Still IDLE: descriptor offered but never taken
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got %b want 0", in_ready); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_we got %b want 0", mem_we); end
        in_valid = 1'b0;
    endtask

    task automatic test_rtype();
        logic r;
        do_start();
        drive(1'b0, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, r);
        n_tests++; if (r !== 1'b1) begin n_fail++; $display("FAIL add_ready got %b want 1", r); end
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL add_we got %b want 1", mem_we); end
        n_tests++; if (mem_addr !== 2'd0) begin n_fail++; $display("FAIL add_addr got %h want 0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h00221820) begin n_fail++; $display("FAIL add_wdata got %h want 00221820", mem_wdata); end
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL add_count got %0d want 1", count); end
        idle_cycle();
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL add_we_drop got %b want 0", mem_we); end
    endtask

    task automatic test_back_to_back();
        logic r;
        do_start();
        drive(1'b0, 1'b1, 3'd4, 5'd9, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0, r);
        n_tests++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h8D280004) begin
            n_fail++; $display("FAIL lw_write got we=%b @%h %h want we=1 @0 8D280004", mem_we, mem_addr, mem_wdata); end
        drive(1'b0, 1'b1, 3'd5, 5'd9, 5'd8, 5'd0, 6'd0, 16'd8, 26'd0, r);
        n_tests++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'hAD280008) begin
            n_fail++; $display("FAIL sw_write got we=%b @%h %h want we=1 @1 AD280008", mem_we, mem_addr, mem_wdata); end
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", count); end
    endtask

    task automatic test_jump_branch();
        logic r;
        do_start();
        drive(1'b0, 1'b1, 3'd1, 5'd7, 5'd7, 5'd7, 6'd0, 16'd0, 26'h0000010, r);
        n_tests++; if (mem_wdata !== 32'h08000010 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL j_word got we=%b %h want we=1 08000010", mem_we, mem_wdata); end
        drive(1'b0, 1'b1, 3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, r);
        n_tests++; if (mem_wdata !== 32'h1022FFFF || mem_addr !== 2'd1) begin
            n_fail++; $display("FAIL beq_word got @%h %h want @1 1022FFFF", mem_addr, mem_wdata); end
    endtask

    task automatic test_illegal();
        logic r;
        do_start();
        drive(1'b0, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, r);
        drive(1'b0, 1'b1, 3'd6, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, r);
        n_tests++; if (r !== 1'b1) begin n_fail++; $display("FAIL ill_ready got %b want 1", r); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ill_we got %b want 0", mem_we); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err got %b want 1", err); end
        drive(1'b0, 1'b1, 3'd5, 5'd9, 5'd8, 5'd0, 6'd0, 16'd8, 26'd0, r);
        n_tests++; if (mem_we !== 1'b1 || mem_addr !== 2'd1) begin
            n_fail++; $display("FAIL ill_next got we=%b @%h want we=1 @1", mem_we, mem_addr); end
        n_tests++; if (count !== 3'd2 || err !== 1'b1) begin
            n_fail++; $display("FAIL ill_sticky got count=%0d err=%b want 2 1", count, err); end
        do_start();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_clear got %b want 0", err); end
    endtask

    task automatic test_full();
        logic r;
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 3'd4, 5'(i), 5'd1, 5'd0, 6'd0, 16'(i), 26'd0, r);
            n_tests++; if (mem_we !== 1'b1 || mem_addr !== AW'(i)) begin
                n_fail++; $display("FAIL fill_write got we=%b @%h want we=1 @%0d", mem_we, mem_addr, i); end
        end
        n_tests++; if (full !== 1'b1 || count !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_flags got full=%b count=%0d ready=%b want 1 4 0", full, count, in_ready); end
        // Fifth descriptor is held while full
        drive(1'b0, 1'b1, 3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'h1234, 26'd0, r);
        n_tests++; if (r !== 1'b0 || mem_we !== 1'b0 || count !== 3'd4) begin
            n_fail++; $display("FAIL full_stall got ready=%b we=%b count=%0d want 0 0 4", r, mem_we, count); end
        drive(1'b1, 1'b1, 3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'h1234, 26'd0, r);
        n_tests++; if (r !== 1'b0 || count !== 3'd0 || full !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL full_restart got ready=%b count=%0d full=%b we=%b want 0 0 0 0", r, count, full, mem_we); end
        drive(1'b0, 1'b1, 3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'h1234, 26'd0, r);
        n_tests++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== ref_enc(3, 4, 5, 0, 0, 'h1234, 0)) begin
            n_fail++; $display("FAIL fifth_write got we=%b @%h %h want we=1 @0 %h", mem_we, mem_addr, mem_wdata, ref_enc(3, 4, 5, 0, 0, 'h1234, 0)); end
    endtask

    task automatic test_reset_midstream();
        logic r;
        do_start();
        drive(1'b0, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, r);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'd0 || count !== '0 || in_ready !== 1'b0 || full !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_async got we=%b addr=%h wdata=%h count=%0d ready=%b want all 0", mem_we, mem_addr, mem_wdata, count, in_ready); end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL rst_hold got we=%b ready=%b count=%0d want 0 0 0", mem_we, in_ready, count); end
    endtask

    task automatic test_random();
        bit          m_run = 1'b0;
        int          m_cnt = 0;
        bit          m_err = 1'b0;
        bit          e_we;
        int          e_addr;
        logic [31:0] e_data;
        for (int i = 0; i < 400; i++) begin
            logic st, v, r, e_rdy;
            int op, rs, rt, rd, fn, imm, tg;
            st  = (i == 0) || ($urandom_range(0, 11) == 0);
            v   = ($urandom_range(0, 3) != 0);
            op  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            rs  = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
            fn  = $urandom_range(0, 63); imm = $urandom_range(0, 65535);
            tg  = $urandom_range(0, 32'h3FFFFFF);
            e_rdy = m_run && (m_cnt < DEPTH) && !st;
            drive(st, v, 3'(op), 5'(rs), 5'(rt), 5'(rd), 6'(fn), 16'(imm), 26'(tg), r);
            e_we = 1'b0;
            if (st) begin
                m_run = 1'b1; m_cnt = 0; m_err = 1'b0;
            end else if (v && e_rdy) begin
                if (op > 5) begin
                    m_err = 1'b1;
                end else begin
                    e_we = 1'b1; e_addr = m_cnt; e_data = ref_enc(op, rs, rt, rd, fn, imm, tg);
                    m_cnt++;
                end
            end
            n_tests++; if (r !== e_rdy) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, r, e_rdy); end
            n_tests++; if (mem_we !== e_we) begin n_fail++; $display("FAIL rnd_we cyc %0d got %b want %b", i, mem_we, e_we); end
            if (e_we) begin
                n_tests++; if (mem_addr !== AW'(e_addr) || mem_wdata !== e_data) begin
                    n_fail++; $display("FAIL rnd_write cyc %0d got @%h %h want @%0d %h", i, mem_addr, mem_wdata, e_addr, e_data); end
            end
            n_tests++; if (count !== (AW+1)'(m_cnt) || full !== (m_cnt == DEPTH) || err !== m_err) begin
                n_fail++; $display("FAIL rnd_status cyc %0d got count=%0d full=%b err=%b want %0d %b %b", i, count, full, err, m_cnt, (m_cnt == DEPTH), m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_jump_branch();
        test_illegal();
        test_full();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
